// File: rtl/lc3_ir_queue.sv
// lc3_ir_queue: small circular instruction-word queue sitting between the
// memory data bus and decode. Words enter on ld_ir and leave on pop. flush
// discards everything on a branch or interrupt redirect. overflow and
// underflow are sticky error flags that only flush or reset clear.
// Every output is a register. The next head word is computed ahead of the
// edge, so ir needs no read path from storage after the clock edge.

module lc3_ir_queue #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         data_bus,
  input  logic                     ld_ir,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         ir,
  output logic                     ir_valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);

  // Storage and registered state
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] ir_r;
  logic             ir_valid_r;
  logic             full_r;
  logic             overflow_r;
  logic             underflow_r;

  // Per-cycle decisions and next-state values
  logic             pop_acc_s;
  logic             push_acc_s;
  logic             ovf_set_s;
  logic             unf_set_s;
  logic [PW-1:0]    wr_next_s;
  logic [PW-1:0]    rd_next_s;
  logic [CW-1:0]    count_next_s;
  logic [WIDTH-1:0] head_next_s;

  // Decide which requests are accepted this cycle. flush overrides both.
  always_comb begin
    pop_acc_s  = 1'b0;
    push_acc_s = 1'b0;
    ovf_set_s  = 1'b0;
    unf_set_s  = 1'b0;
    if (flush) begin
      pop_acc_s  = 1'b0;
      push_acc_s = 1'b0;
      ovf_set_s  = 1'b0;
      unf_set_s  = 1'b0;
    end else begin
      pop_acc_s  = pop && (count_r != CNT_ZERO);
      // A full queue still takes a push when a pop frees the head slot on the same edge.
      push_acc_s = ld_ir && ((count_r != DEPTH_C) || pop_acc_s);
      ovf_set_s  = ld_ir && !push_acc_s;
      unf_set_s  = pop && (count_r == CNT_ZERO);
    end
  end

  // Next pointers and occupancy.
  always_comb begin
    wr_next_s    = wr_ptr_r;
    rd_next_s    = rd_ptr_r;
    count_next_s = count_r;
    if (flush) begin
      wr_next_s    = PTR_ZERO;
      rd_next_s    = PTR_ZERO;
      count_next_s = CNT_ZERO;
    end else begin
      if (push_acc_s) begin
        wr_next_s = wr_ptr_r + PTR_ONE;
      end else begin
        wr_next_s = wr_ptr_r;
      end
      if (pop_acc_s) begin
        rd_next_s = rd_ptr_r + PTR_ONE;
      end else begin
        rd_next_s = rd_ptr_r;
      end
      case ({push_acc_s, pop_acc_s})
        2'b10:   count_next_s = count_r + CNT_ONE;
        2'b01:   count_next_s = count_r - CNT_ONE;
        default: count_next_s = count_r;
      endcase
    end
  end

  // Head word after this edge. It is the incoming word when that word lands
  // in the slot that becomes the head. This happens when the queue goes from
  // empty to one entry, or when one entry is replaced by a push and a pop.
  always_comb begin
    head_next_s = {WIDTH{1'b0}};
    if (count_next_s == CNT_ZERO) begin
      head_next_s = {WIDTH{1'b0}};
    end else if (push_acc_s && (wr_ptr_r == rd_next_s)) begin
      head_next_s = data_bus;
    end else begin
      head_next_s = mem_r[rd_next_s];
    end
  end

  // Entry storage: written only by an accepted push, cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (push_acc_s) begin
      mem_r[wr_ptr_r] <= data_bus;
    end
  end

  // Pointers, occupancy, registered outputs and sticky error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r    <= PTR_ZERO;
      rd_ptr_r    <= PTR_ZERO;
      count_r     <= CNT_ZERO;
      ir_r        <= {WIDTH{1'b0}};
      ir_valid_r  <= 1'b0;
      full_r      <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      wr_ptr_r    <= wr_next_s;
      rd_ptr_r    <= rd_next_s;
      count_r     <= count_next_s;
      ir_r        <= head_next_s;
      ir_valid_r  <= (count_next_s != CNT_ZERO);
      full_r      <= (count_next_s == DEPTH_C);
      if (flush) begin
        overflow_r  <= 1'b0;
        underflow_r <= 1'b0;
      end else begin
        overflow_r  <= overflow_r | ovf_set_s;
        underflow_r <= underflow_r | unf_set_s;
      end
    end
  end

  assign ir        = ir_r;
  assign ir_valid  = ir_valid_r;
  assign full      = full_r;
  assign count     = count_r;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;

endmodule

// File: tb/tb_lc3_ir_queue.sv
// Bench for lc3_ir_queue. It runs directed scenarios and then random
// traffic. The expected values come from a queue-based reference model.

module tb_lc3_ir_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] data_bus = 16'h0000;
  logic        ld_ir = 1'b0;
  logic        pop = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] ir;
  logic        ir_valid;
  logic        full;
  logic [2:0]  count;
  logic        overflow;
  logic        underflow;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [15:0] mq[$];
  bit          ovf_m = 1'b0;
  bit          unf_m = 1'b0;
  bit          ld_v, p_v, f_v;
  logic [15:0] d_v;

  always #5 clk = ~clk;

  lc3_ir_queue #(.WIDTH(16), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .data_bus(data_bus), .ld_ir(ld_ir), .pop(pop),
    .flush(flush), .ir(ir), .ir_valid(ir_valid), .full(full), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit l, input logic [15:0] d, input bit p, input bit f);
    ld_v = l; d_v = d; p_v = p; f_v = f;
    ld_ir = l; data_bus = d; pop = p; flush = f;
  endtask

  // One clock edge in queue terms: flush empties; otherwise pop then push.
  task automatic model_edge();
    bit pop_ok, push_ok;
    if (f_v) begin
      mq.delete();
      ovf_m = 1'b0;
      unf_m = 1'b0;
    end else begin
      pop_ok  = p_v && (mq.size() > 0);
      push_ok = ld_v && ((mq.size() < DEPTH) || pop_ok);
      if (ld_v && !push_ok) ovf_m = 1'b1;
      if (p_v && mq.size() == 0) unf_m = 1'b1;
      if (pop_ok) void'(mq.pop_front());
      if (push_ok) mq.push_back(d_v);
    end
  endtask

  task automatic check_model();
    logic [15:0] head;
    head = (mq.size() > 0) ? mq[0] : 16'h0000;
    check_val("count", {29'd0, count}, mq.size());
    check_val("ir", {16'd0, ir}, {16'd0, head});
    check_val("ir_valid", {31'd0, ir_valid}, {31'd0, mq.size() > 0});
    check_val("full", {31'd0, full}, {31'd0, mq.size() == DEPTH});
    check_val("overflow", {31'd0, overflow}, {31'd0, ovf_m});
    check_val("underflow", {31'd0, underflow}, {31'd0, unf_m});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic cyc(input bit l, input logic [15:0] d, input bit p, input bit f);
    drive(l, d, p, f);
    tick();
  endtask

  logic [15:0] words [4];
  logic [15:0] after_sim [4];

  initial begin
    words[0] = 16'h1234; words[1] = 16'h5678; words[2] = 16'h9ABC; words[3] = 16'hDEF0;
    after_sim[0] = 16'h5678; after_sim[1] = 16'h9ABC; after_sim[2] = 16'hDEF0; after_sim[3] = 16'hBEEF;
    drive(1'b0, 16'h0000, 1'b0, 1'b0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_model();
    rst = 1'b1;

    // Fill and drain
    for (int i = 0; i < 4; i++) cyc(1'b1, words[i], 1'b0, 1'b0);
    check_val("fill_full", {31'd0, full}, 32'd1);
    check_val("fill_count", {29'd0, count}, 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_val("drain_ir", {16'd0, ir}, {16'd0, words[i]});
      cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    end
    check_val("drain_count", {29'd0, count}, 32'd0);
    check_val("drain_ir0", {16'd0, ir}, 32'd0);

    // Overflow: a dropped push sets the sticky flag and never appears in the drain
    for (int i = 0; i < 4; i++) cyc(1'b1, words[i], 1'b0, 1'b0);
    cyc(1'b1, 16'hAAAA, 1'b0, 1'b0);
    check_val("ovf_flag", {31'd0, overflow}, 32'd1);
    check_val("ovf_count", {29'd0, count}, 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_val("ovf_drain", {16'd0, ir}, {16'd0, words[i]});
      cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    end
    check_val("ovf_sticky", {31'd0, overflow}, 32'd1);
    cyc(1'b0, 16'h0000, 1'b0, 1'b1);
    check_val("ovf_flush", {31'd0, overflow}, 32'd0);

    // Push and pop together on a full queue: pointer wrap
    for (int i = 0; i < 4; i++) cyc(1'b1, words[i], 1'b0, 1'b0);
    cyc(1'b1, 16'hBEEF, 1'b1, 1'b0);
    check_val("sim_count", {29'd0, count}, 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_val("sim_drain", {16'd0, ir}, {16'd0, after_sim[i]});
      cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    end

    // Underflow, then no bypass on a push into an empty queue
    cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    check_val("unf_flag", {31'd0, underflow}, 32'd1);
    check_val("unf_count", {29'd0, count}, 32'd0);
    drive(1'b1, 16'h0F0F, 1'b0, 1'b0);
    #1;
    check_val("nobypass_ir", {16'd0, ir}, 32'd0);
    check_val("nobypass_valid", {31'd0, ir_valid}, 32'd0);
    tick();
    check_val("push_ir", {16'd0, ir}, 32'h0000_0F0F);
    cyc(1'b0, 16'h0000, 1'b0, 1'b1);

    // Flush has priority over a concurrent push and pop
    cyc(1'b1, 16'h4444, 1'b0, 1'b0);
    cyc(1'b1, 16'h5555, 1'b0, 1'b0);
    cyc(1'b1, 16'h1111, 1'b1, 1'b1);
    check_val("flush_count", {29'd0, count}, 32'd0);
    check_val("flush_valid", {31'd0, ir_valid}, 32'd0);
    check_val("flush_ir", {16'd0, ir}, 32'd0);
    cyc(1'b1, 16'h3333, 1'b0, 1'b0);
    check_val("flush_head", {16'd0, ir}, 32'h0000_3333);

    // Asynchronous reset while the queue holds three words
    cyc(1'b1, 16'h00A2, 1'b0, 1'b0);
    cyc(1'b1, 16'h00A3, 1'b1, 1'b0);
    cyc(1'b1, 16'h00A4, 1'b0, 1'b0);
    check_val("pre_rst_count", {29'd0, count}, 32'd3);
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    #3;
    rst = 1'b0;
    mq.delete();
    ovf_m = 1'b0;
    unf_m = 1'b0;
    #1;
    check_model();
    check_val("arst_count", {29'd0, count}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(1'b1, 16'h2222, 1'b0, 1'b0);
    check_val("arst_head", {16'd0, ir}, 32'h0000_2222);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      cyc($urandom_range(0, 99) < 55, 16'($urandom), $urandom_range(0, 99) < 50,
          $urandom_range(0, 99) < 4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
